// File: rtl/bitty_fetch_if.sv
// Signal bundle between the bitty fetch unit and its environment:
// start/stop control, instruction memory read port, core launch/done and status.
interface bitty_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic [15:0]       mem_rdata;
    logic              mem_valid;
    logic [15:0]       instruction;
    logic              run;
    logic              done;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              error;
    logic [15:0]       instr_count;

    modport master (
        input  start, stop, start_addr, last_addr, mem_rdata, mem_valid, done,
        output mem_addr, mem_req, instruction, run, pc, busy, halted, error, instr_count
    );

    modport slave (
        output start, stop, start_addr, last_addr, mem_rdata, mem_valid, done,
        input  mem_addr, mem_req, instruction, run, pc, busy, halted, error, instr_count
    );
endinterface

// File: rtl/bitty_fetch.sv
// Instruction fetch/sequencer for the bitty core: fetches one word, pulses run,
// waits for done (with a watchdog) and steps the PC until last_addr or a stop.
module bitty_fetch #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    bitty_fetch_if.master bus
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_NEXT
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_last;
    logic [15:0]       r_instr;
    logic [15:0]       r_cnt;
    logic              r_req;
    logic              r_run;
    logic              r_halted;
    logic              r_error;
    logic              r_stop_pend;
    logic [WD_W-1:0]   r_wdog;

    logic [WD_W-1:0]   w_wdog_nxt;
    logic              w_busy;

    assign w_busy     = (r_state != S_IDLE);
    assign w_wdog_nxt = r_wdog + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_last      <= '0;
            r_instr     <= '0;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_run       <= 1'b0;
            r_halted    <= 1'b0;
            r_error     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_run <= 1'b0;
            // stop only arms while a program is running; IDLE start clears it below
            if (w_busy && bus.stop) begin
                r_stop_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pc        <= bus.start_addr;
                        r_last      <= bus.last_addr;
                        r_cnt       <= '0;
                        r_halted    <= 1'b0;
                        r_error     <= 1'b0;
                        r_stop_pend <= 1'b0;
                        r_req       <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.mem_valid) begin
                        r_instr <= bus.mem_rdata;
                        r_req   <= 1'b0;
                        r_run   <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.done) begin
                        r_cnt   <= r_cnt + 16'd1;
                        r_state <= S_NEXT;
                    end else if (w_wdog_nxt == WD_W'(TIMEOUT - 1)) begin
                        // pc is left on the hung instruction for post-mortem
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_wdog <= w_wdog_nxt;
                    end
                end
                S_NEXT: begin
                    if ((r_pc == r_last) || r_stop_pend) begin
                        r_halted <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_pc    <= r_pc + 1'b1;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr    = r_pc;
    assign bus.mem_req     = r_req;
    assign bus.instruction = r_instr;
    assign bus.run         = r_run;
    assign bus.pc          = r_pc;
    assign bus.busy        = w_busy;
    assign bus.halted      = r_halted;
    assign bus.error       = r_error;
    assign bus.instr_count = r_cnt;
endmodule

// File: tb/tb_bitty_fetch.sv
// Scoreboard bench for bitty_fetch: random memory/core responders, a program-level
// reference model filling an expectation queue, and a monitor checking every run pulse.
module tb_bitty_fetch;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bitty_fetch_if #(.ADDR_W(ADDR_W)) bif ();

    bitty_fetch #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] cnt;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] mem [256];
    exp_t        exp_q [$];
    int          plan_d      [300];
    bit          plan_stop   [300];
    int          plan_stop_s [300];
    bit          plan_spur   [300];
    int          n_plan  = 0;
    int          run_idx = 0;
    int          mem_lat = 1;
    bit          mem_hold = 1'b0;
    logic        valid_sampled = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) valid_sampled <= bif.mem_valid;

    // Instruction memory: answers each request mem_lat cycles after it is seen.
    initial begin : mem_resp
        int lat_cnt;
        lat_cnt = 0;
        bif.mem_valid = 1'b0;
        bif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!mem_hold) begin
                bif.mem_valid = 1'b0;
                bif.mem_rdata = 16'($urandom);
                if (rst && bif.mem_req) begin
                    lat_cnt++;
                    if (lat_cnt >= mem_lat) begin
                        bif.mem_valid = 1'b1;
                        bif.mem_rdata = mem[bif.mem_addr];
                        lat_cnt = 0;
                    end
                end else begin
                    lat_cnt = 0;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Core model: plan_d cycles after run it raises done (0 = hang forever).
    initial begin : core_resp
        int idx, d, ss, cnt;
        bit st, sp;
        bif.done = 1'b0;
        bif.stop = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && bif.run) begin
                idx = run_idx;
                run_idx++;
                if (idx < n_plan) begin
                    d = plan_d[idx]; st = plan_stop[idx]; ss = plan_stop_s[idx]; sp = plan_spur[idx];
                end else begin
                    d = 1; st = 1'b0; ss = 0; sp = 1'b0;
                end
                if (d == 0) begin
                    cnt = 0;
                    while (!bif.error && cnt < TIMEOUT + 8) begin
                        @(negedge clk);
                        cnt++;
                    end
                    check("timeout_latency", 32'(cnt), 32'(TIMEOUT));
                    check("timeout_busy", 32'(bif.busy), 32'(0));
                end else begin
                    bif.done = sp;
                    bif.stop = st && (ss == 0);
                    for (int s = 1; s <= d; s++) begin
                        @(negedge clk);
                        bif.done = (s == d);
                        bif.stop = st && (ss == s);
                    end
                    @(negedge clk);
                    bif.done = 1'b0;
                    bif.stop = 1'b0;
                end
            end
        end
    end

    // Monitor: every run pulse must match the next planned instruction.
    initial begin : monitor
        int         req_len;
        bit         unstable, prev_req, prev_run;
        logic [7:0] prev_addr;
        exp_t       e;
        req_len = 0; unstable = 1'b0; prev_req = 1'b0; prev_run = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                req_len = 0; unstable = 1'b0; prev_req = 1'b0; prev_run = 1'b0;
            end else begin
                if (bif.mem_req) begin
                    if (prev_req && bif.mem_addr != prev_addr) unstable = 1'b1;
                    req_len++;
                end
                prev_req  = bif.mem_req;
                prev_addr = bif.mem_addr;
                if (bif.run) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_run: run with pc=0x%0h, expected no run", bif.pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("run_pc", 32'(bif.pc), 32'(e.addr));
                        check("run_instruction", 32'(bif.instruction), 32'(e.data));
                        check("run_instr_count", 32'(bif.instr_count), 32'(e.cnt));
                        check("req_cycles", 32'(req_len), 32'(mem_lat));
                        check("req_addr_stable", 32'(unstable), 32'(0));
                        check("run_after_valid", 32'(valid_sampled), 32'(1));
                        check("run_single_cycle", 32'(prev_run), 32'(0));
                    end
                    req_len  = 0;
                    unstable = 1'b0;
                end
                prev_run = bif.run;
            end
        end
    end

    task automatic run_job(input logic [7:0] sa, input logic [7:0] la, input int lat,
                           input int dmin, input int dmax, input int stop_idx,
                           input int to_idx, input bit stop_with_start);
        logic [7:0] diff, end_pc, a;
        int         n_total, n_runs, exp_cnt, cyc, poke;
        bit         exp_err;
        exp_t       e;
        diff    = la - sa;
        n_total = int'(diff) + 1;
        if (to_idx >= 0 && to_idx < n_total && (stop_idx < 0 || to_idx <= stop_idx)) begin
            n_runs = to_idx + 1; exp_cnt = to_idx; exp_err = 1'b1;
        end else begin
            n_runs = n_total;
            if (stop_idx >= 0 && stop_idx < n_total) n_runs = stop_idx + 1;
            exp_cnt = n_runs; exp_err = 1'b0;
        end
        end_pc = sa + 8'(n_runs - 1);
        for (int i = 0; i < n_total; i++) begin
            plan_d[i]      = (i == to_idx) ? 0 : int'($urandom_range(dmax, dmin));
            plan_stop[i]   = (i == stop_idx);
            plan_stop_s[i] = int'($urandom_range(plan_d[i], 0));
            plan_spur[i]   = ($urandom % 4 == 0);
        end
        n_plan = n_total;
        for (int i = 0; i < n_runs; i++) begin
            a = sa + 8'(i);
            e.addr = a; e.data = mem[a]; e.cnt = 16'(i);
            exp_q.push_back(e);
        end
        run_idx = 0;
        mem_lat = lat;
        @(negedge clk);
        bif.start_addr = sa;
        bif.last_addr  = la;
        bif.start      = 1'b1;
        bif.stop       = stop_with_start;
        @(negedge clk);
        bif.start      = 1'b0;
        bif.stop       = 1'b0;
        bif.start_addr = 8'($urandom);
        bif.last_addr  = 8'($urandom);
        check("start_state", 32'({bif.busy, bif.halted, bif.error, bif.instr_count}),
              32'({1'b1, 1'b0, 1'b0, 16'd0}));
        poke = int'($urandom_range(12, 1));
        cyc  = 0;
        while (bif.busy && cyc < 20000) begin
            if (cyc == poke) begin
                bif.start      = 1'b1;
                bif.start_addr = 8'($urandom);
                bif.last_addr  = 8'($urandom);
            end
            @(negedge clk);
            bif.start = 1'b0;
            cyc++;
        end
        check("job_finished", 32'(bif.busy), 32'(0));
        check("end_halted", 32'(bif.halted), 32'(!exp_err));
        check("end_error", 32'(bif.error), 32'(exp_err));
        check("end_instr_count", 32'(bif.instr_count), 32'(exp_cnt));
        check("end_pc", 32'(bif.pc), 32'(end_pc));
        check("end_run_pulses", 32'(run_idx), 32'(n_runs));
        check("end_queue_empty", 32'(exp_q.size()), 32'(0));
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        int sidx, tidx;
        logic [7:0] sa;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        bif.start = 1'b0;
        bif.start_addr = '0;
        bif.last_addr = '0;
        #2;
        check("reset_outputs", 32'({bif.mem_addr, bif.mem_req, bif.instruction, bif.run, bif.pc,
                                    bif.busy, bif.halted, bif.error}), 32'(0));
        check("reset_instr_count", 32'(bif.instr_count), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_job(8'h10, 8'h12, 1, 3, 3, -1, -1, 1'b0);
        run_job(8'h20, 8'h22, 4, 1, 5, -1, -1, 1'b0);
        run_job(8'h04, 8'h20, 2, 3, 3, 1, -1, 1'b0);
        run_job(8'h40, 8'h45, 1, 1, 3, -1, 0, 1'b0);
        run_job(8'hFE, 8'h01, 2, 1, 4, -1, -1, 1'b0);
        run_job(8'h77, 8'h77, 3, 1, 2, -1, -1, 1'b0);
        run_job(8'h50, 8'h53, 1, 1, 2, -1, -1, 1'b1);
        run_job(8'h60, 8'h66, 2, 2, 4, -1, 3, 1'b0);

        for (int j = 0; j < 12; j++) begin
            sa   = 8'($urandom);
            sidx = ($urandom % 3 == 0) ? int'($urandom_range(6, 0)) : -1;
            tidx = ($urandom % 5 == 0) ? int'($urandom_range(4, 0)) : -1;
            run_job(sa, sa + 8'($urandom_range(10, 0)), int'($urandom_range(5, 1)),
                    1, 6, sidx, tidx, 1'($urandom % 2));
        end

        // Reset in the middle of a fetch, then a stray mem_valid after release.
        mem_hold = 1'b1;
        bif.mem_valid = 1'b0;
        @(negedge clk);
        bif.start_addr = 8'h30;
        bif.last_addr  = 8'h40;
        bif.start      = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (3) @(negedge clk);
        check("fetch_req_held", 32'({bif.mem_req, bif.busy}), 32'(2'b11));
        check("fetch_addr", 32'(bif.mem_addr), 32'(8'h30));
        #2 rst = 1'b0;
        #1;
        check("async_reset_outputs", 32'({bif.mem_addr, bif.mem_req, bif.instruction, bif.run,
                                          bif.pc, bif.busy, bif.halted, bif.error}), 32'(0));
        check("async_reset_count", 32'(bif.instr_count), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        bif.mem_valid = 1'b1;
        bif.mem_rdata = 16'hBEEF;
        @(negedge clk);
        bif.mem_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("late_valid_ignored", 32'({bif.busy, bif.run, bif.mem_req, bif.instruction}), 32'(0));
        mem_hold = 1'b0;
        run_job(8'h08, 8'h09, 1, 1, 3, -1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : global_guard
        #3000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/bitty_fetch.md
Name: bitty_fetch

Overview:
Instruction fetch/sequencer that sits directly upstream of the bitty core. It walks a program counter through instruction memory and presents each word on `instruction`. It pulses `run` to launch execution and waits for the core's `done` before fetching the next word. It also provides start/stop control, an end-of-program address, and a per-instruction watchdog.

Parameters:
ADDR_W, 8, program counter / memory address width
TIMEOUT, 64, max cycles to wait for done after run before flagging error (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  begin fetching at start_addr; honoured only in IDLE
stop  input  1  request halt after the current instruction completes
start_addr  input  ADDR_W  first PC loaded on start
last_addr  input  ADDR_W  address of final instruction; sampled at start
mem_addr  output  ADDR_W  instruction memory read address (= pc)
mem_req  output  1  read request, held until mem_valid
mem_rdata  input  16  read data, valid when mem_valid=1
mem_valid  input  1  read data strobe, 1 cycle, arbitrary latency >=1 cycle after mem_req
instruction  output  16  instruction word to core
run  output  1  1-cycle launch pulse to core
done  input  1  core completion strobe
pc  output  ADDR_W  current program counter
busy  output  1  1 in any state except IDLE
halted  output  1  sticky; set on normal end (last_addr reached or stop), cleared on start
error  output  1  sticky; set on watchdog timeout, cleared on start
instr_count  output  16  instructions completed since start, wraps at 2^16

Behaviour:
- Reset (rst=0, async): state=IDLE; pc, mem_addr, instruction, instr_count=0; mem_req, run, busy, halted, error=0; internal last, stop_pending and watchdog cleared.
- States: IDLE, FETCH, ISSUE, WAIT, NEXT.
- IDLE:
  - On start=1: pc<=start_addr, last<=last_addr, instr_count<=0, halted<=0, error<=0, stop_pending<=0, go to FETCH.
  - start is ignored in every other state.
- FETCH:
  - mem_req=1, mem_addr=pc, held stable.
  - On mem_valid=1: instruction<=mem_rdata, mem_req deasserts next cycle, go to ISSUE.
  - mem_valid outside FETCH is ignored.
- ISSUE:
  - run=1 for exactly this one cycle; watchdog<=0; go to WAIT.
  - instruction is held constant from ISSUE until the next FETCH completes.
- WAIT:
  - done is sampled only here, so a done in the ISSUE cycle is ignored; earliest accepted done is 1 cycle after run.
  - Watchdog increments each cycle.
  - On done=1: instr_count++, go to NEXT.
  - Else if watchdog reaches TIMEOUT-1: error<=1, go to IDLE, pc unchanged (points at the hung instruction).
- NEXT:
  - If pc==last or stop_pending: halted<=1, go to IDLE, pc holds last executed address.
  - Else pc<=pc+1 (mod 2^ADDR_W; wrap from all-ones to 0 is legal), go to FETCH.
- stop:
  - Any cycle with busy=1 sets stop_pending; it takes effect at NEXT.
  - A stop in the same cycle as done is honoured.
  - stop while IDLE has no effect.
- start and stop asserted together in IDLE: start wins; stop is not latched that cycle.
- Latency per instruction: FETCH (mem latency L) + 1 ISSUE + D (WAIT until done) + 1 NEXT cycles.
  - Back-to-back throughput is L+D+2 cycles per instruction.
- start_addr==last_addr: exactly one instruction executes.
- If last_addr<start_addr, pc wraps through 0 to reach last.
- Reset asserted mid-operation returns to reset values immediately; any outstanding mem read is dropped.
- All outputs are registered except busy and mem_addr, which are decoded from registered state/pc.

Test Plan:
- Reset then start=1, start_addr=0x10, last_addr=0x12, memory latency 1, done 3 cycles after each run -> 3 run pulses carrying mem[0x10..0x12]; after the third done, halted=1, busy=0, instr_count=3, pc=0x12.
- Memory latency 4 cycles -> mem_req stays high 4 cycles with mem_addr stable; run fires the cycle after mem_valid; instruction equals mem_rdata.
- stop pulsed during WAIT of instruction at 0x05 (start 0x04, last 0x20) -> that instruction completes, no further fetch, halted=1, pc=0x05, instr_count=2.
- Core never asserts done, TIMEOUT=64 -> error=1 and busy=0 exactly 64 cycles after run; pc holds the stalled address; a subsequent start clears error.
- ADDR_W=8, start_addr=0xFE, last_addr=0x01 -> fetch order 0xFE, 0xFF, 0x00, 0x01; instr_count=4.
- rst driven low during FETCH with mem_req=1 -> all outputs zero immediately; a late mem_valid after reset is ignored, and the block stays IDLE until start.
